// File: rtl/neo_rst_pkg.sv
// Shared types, widths and default cycle constants for the NeoGeo reset generator.
package neo_rst_pkg;

  localparam int WDOG_CNT_W       = 4;
  localparam int DEF_POR_CYCLES   = 4096;
  localparam int DEF_WDOG_FRAMES  = 8;
  localparam int DEF_PULSE_CYCLES = 256;

  typedef enum logic [1:0] {
    ST_POR   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  // Width needed to count 0 .. max(a,b)-1, never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/neo_rst_stretch.sv
// Reset-stretch counter shared by the power-on hold and the watchdog pulse;
// done is high while the count equals the selected last value.
module neo_rst_stretch #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] last,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = (cnt == last);

endmodule

// File: rtl/neo_wdog_rstgen.sv
// NeoGeo reset request generator: power-on hold plus VBLANK-counted watchdog.
// Define NEO_WDOG_STATUS_EN to add the sticky WDOG_FIRED flag and its WDOG_CLR input.
module neo_wdog_rstgen
  import neo_rst_pkg::*;
#(
  parameter int POR_CYCLES   = DEF_POR_CYCLES,
  parameter int WDOG_FRAMES  = DEF_WDOG_FRAMES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  CLK_EN_24_N,
  input  logic                  VBLANK,
  input  logic                  WDOG_KICK,
  input  logic                  WDOG_DIS,
  output logic                  nRESET_REQ,
  output logic [WDOG_CNT_W-1:0] WDOG_CNT
`ifdef NEO_WDOG_STATUS_EN
  ,
  output logic                  WDOG_FIRED,
  input  logic                  WDOG_CLR
`endif
);

  localparam int CW = cnt_width(POR_CYCLES, PULSE_CYCLES);
  localparam logic [CW-1:0]         POR_LAST    = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0]         PULSE_LAST  = CW'(PULSE_CYCLES - 1);
  localparam logic [WDOG_CNT_W-1:0] FRAMES_LAST = WDOG_CNT_W'(WDOG_FRAMES - 1);

  state_t                  state;
  logic                    req;
  logic [WDOG_CNT_W-1:0]   wdog_cnt;
  logic                    kick_pend;
  logic                    vb_d;
  logic                    en;
  logic                    kick;
  logic                    vb_rise;
  logic                    fire;
  logic                    holding;
  logic                    st_done;
  logic [CW-1:0]           st_last;

  assign en      = CLK_EN_24_N;
  // A kick arriving on the enable cycle itself counts immediately.
  assign kick    = kick_pend | WDOG_KICK;
  assign vb_rise = VBLANK & ~vb_d;
  assign holding = (state != ST_RUN);
  assign st_last = (state == ST_POR) ? POR_LAST : PULSE_LAST;
  assign fire    = en && (state == ST_RUN) && vb_rise && !kick && !WDOG_DIS &&
                   (wdog_cnt == FRAMES_LAST);

  neo_rst_stretch #(.CW(CW)) u_stretch (
    .clk   (CLK),
    .rst_n (nRESET),
    .clr   (en & holding & st_done),
    .inc   (en & holding & ~st_done),
    .last  (st_last),
    .done  (st_done)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      kick_pend <= 1'b0;
      vb_d      <= 1'b0;
    end else if (en) begin
      kick_pend <= 1'b0;
      vb_d      <= VBLANK;
    end else if (WDOG_KICK) begin
      kick_pend <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= ST_POR;
      req      <= 1'b0;
      wdog_cnt <= '0;
    end else if (en) begin
      case (state)
        ST_POR: begin
          if (st_done) begin
            state <= ST_RUN;
            req   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (kick || WDOG_DIS) begin
            wdog_cnt <= '0;
          end else if (fire) begin
            state    <= ST_PULSE;
            req      <= 1'b0;
            wdog_cnt <= '0;
          end else if (vb_rise) begin
            wdog_cnt <= wdog_cnt + WDOG_CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (st_done) begin
            state <= ST_RUN;
            req   <= 1'b1;
          end
        end
        default: begin
          state <= ST_POR;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign nRESET_REQ = req;
  assign WDOG_CNT   = wdog_cnt;

`ifdef NEO_WDOG_STATUS_EN
  logic fired;

  // Set wins over a clear in the same cycle.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      fired <= 1'b0;
    end else if (fire) begin
      fired <= 1'b1;
    end else if (WDOG_CLR) begin
      fired <= 1'b0;
    end
  end

  assign WDOG_FIRED = fired;
`endif

endmodule

// File: tb/tb_neo_wdog_rstgen.sv
// Self-checking bench for neo_wdog_rstgen with POR=16, FRAMES=3, PULSE=8 and a half-rate enable.
module tb_neo_wdog_rstgen;

  localparam int POR   = 16;
  localparam int FRM   = 3;
  localparam int PULSE = 8;

  logic       CLK;
  logic       nRESET;
  logic       CLK_EN_24_N;
  logic       VBLANK;
  logic       WDOG_KICK;
  logic       WDOG_DIS;
  logic       WDOG_CLR;
  logic       nRESET_REQ;
  logic [3:0] WDOG_CNT;
`ifdef NEO_WDOG_STATUS_EN
  logic       WDOG_FIRED;
`endif

  int checks   = 0;
  int failures = 0;
  bit en_hold  = 1'b0;

  neo_wdog_rstgen #(.POR_CYCLES(POR), .WDOG_FRAMES(FRM), .PULSE_CYCLES(PULSE)) dut (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .CLK_EN_24_N (CLK_EN_24_N),
    .VBLANK      (VBLANK),
    .WDOG_KICK   (WDOG_KICK),
    .WDOG_DIS    (WDOG_DIS),
    .nRESET_REQ  (nRESET_REQ),
    .WDOG_CNT    (WDOG_CNT)
`ifdef NEO_WDOG_STATUS_EN
    ,
    .WDOG_FIRED  (WDOG_FIRED),
    .WDOG_CLR    (WDOG_CLR)
`endif
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: remaining low-enables plus frames seen since the last kick.
  int m_low, m_frames, n_low, n_frames;
  bit m_req, m_pend, m_vb, m_fired, n_req, n_pend, n_vb, n_fired;

  always_comb begin
    n_low    = m_low;
    n_frames = m_frames;
    n_req    = m_req;
    n_pend   = m_pend;
    n_vb     = m_vb;
    n_fired  = m_fired;
    if (CLK_EN_24_N) begin
      n_vb   = VBLANK;
      n_pend = 1'b0;
      if (m_low > 0) begin
        n_low = m_low - 1;
        n_req = (n_low == 0);
      end else if (m_pend || WDOG_KICK || WDOG_DIS) begin
        n_frames = 0;
      end else if (VBLANK && !m_vb) begin
        n_frames = m_frames + 1;
        if (n_frames == FRM) begin
          n_frames = 0;
          n_low    = PULSE;
          n_req    = 1'b0;
          n_fired  = 1'b1;
        end
      end
    end else if (WDOG_KICK) begin
      n_pend = 1'b1;
    end
    if (!(n_fired && !m_fired) && WDOG_CLR) n_fired = 1'b0;
  end

  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      m_low <= POR; m_frames <= 0; m_req <= 1'b0;
      m_pend <= 1'b0; m_vb <= 1'b0; m_fired <= 1'b0;
    end else begin
      m_low <= n_low; m_frames <= n_frames; m_req <= n_req;
      m_pend <= n_pend; m_vb <= n_vb; m_fired <= n_fired;
    end
  end

  // driver tasks
  task automatic cycle();
    @(negedge CLK);
    if (en_hold) CLK_EN_24_N = 1'b0;
    else         CLK_EN_24_N = ~CLK_EN_24_N;
  endtask

  task automatic frame();
    VBLANK = 1'b1;
    repeat (4) cycle();
    VBLANK = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic kick_now();
    WDOG_KICK = 1'b1;
    cycle();
    WDOG_KICK = 1'b0;
    repeat (3) cycle();
  endtask

  // Runs until nRESET_REQ equals v; n counts enabled edges taken, ok flags success.
  task automatic wait_req(input logic v, input int max_cyc, output int n, output bit ok);
    logic e;
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      e = CLK_EN_24_N;
      cycle();
      if (e) n++;
      if (nRESET_REQ === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n; bit ok;
    nRESET = 1'b0;
    repeat (3) cycle();
    checks++;
    if (nRESET_REQ !== 1'b0 || WDOG_CNT !== 4'd0) begin
      failures++;
      $display("FAIL reset_values: req=%b cnt=%0d want req=0 cnt=0", nRESET_REQ, WDOG_CNT);
    end
    nRESET = 1'b1;
    wait_req(1'b1, 200, n, ok);
    checks++;
    if (!ok || n != POR) begin
      failures++;
      $display("FAIL por_length: ok=%0d enables=%0d want %0d", ok, n, POR);
    end
    checks++;
    if (WDOG_CNT !== 4'd0) begin
      failures++;
      $display("FAIL por_cnt: got %0d want 0", WDOG_CNT);
    end
  endtask

  task automatic test_timeout();
    int n; bit ok;
    for (int f = 1; f < FRM; f++) begin
      frame();
      checks++;
      if (WDOG_CNT !== 4'(f) || nRESET_REQ !== 1'b1) begin
        failures++;
        $display("FAIL timeout_frame%0d: cnt=%0d req=%b want cnt=%0d req=1", f, WDOG_CNT, nRESET_REQ, f);
      end
    end
    VBLANK = 1'b1;
    wait_req(1'b0, 6, n, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_fire: req=%b want 0", nRESET_REQ);
    end
    wait_req(1'b1, 60, n, ok);
    checks++;
    if (!ok || n != PULSE) begin
      failures++;
      $display("FAIL pulse_length: ok=%0d enables=%0d want %0d", ok, n, PULSE);
    end
    VBLANK = 1'b0;
    repeat (4) cycle();
    checks++;
    if (WDOG_CNT !== 4'd0) begin
      failures++;
      $display("FAIL timeout_cnt_after: got %0d want 0", WDOG_CNT);
    end
  endtask

  task automatic test_kick_nonenable();
    int n; bit ok;
    frame();
    frame();
    if (CLK_EN_24_N) cycle();
    kick_now();
    checks++;
    if (WDOG_CNT !== 4'd0) begin
      failures++;
      $display("FAIL kick_nonenable: cnt=%0d want 0", WDOG_CNT);
    end
    frame();
    frame();
    checks++;
    if (WDOG_CNT !== 4'd2 || nRESET_REQ !== 1'b1) begin
      failures++;
      $display("FAIL kick_two_more: cnt=%0d req=%b want cnt=2 req=1", WDOG_CNT, nRESET_REQ);
    end
    VBLANK = 1'b1;
    wait_req(1'b0, 6, n, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL kick_third_fire: req=%b want 0", nRESET_REQ);
    end
    wait_req(1'b1, 60, n, ok);
    VBLANK = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_kick_coincident();
    frame();
    frame();
    if (!CLK_EN_24_N) cycle();
    VBLANK    = 1'b1;
    WDOG_KICK = 1'b1;
    cycle();
    WDOG_KICK = 1'b0;
    repeat (3) cycle();
    checks++;
    if (WDOG_CNT !== 4'd0 || nRESET_REQ !== 1'b1) begin
      failures++;
      $display("FAIL kick_coincident: cnt=%0d req=%b want cnt=0 req=1", WDOG_CNT, nRESET_REQ);
    end
    VBLANK = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_disable();
    int n, e_cnt; bit ok, bad;
    logic e;
    WDOG_DIS = 1'b1;
    bad = 1'b0;
    for (int f = 0; f < 20; f++) begin
      frame();
      if (WDOG_CNT !== 4'd0 || nRESET_REQ !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL disable_frames: cnt=%0d req=%b want cnt=0 req=1", WDOG_CNT, nRESET_REQ);
    end
    WDOG_DIS = 1'b0;
    frame();
    frame();
    VBLANK = 1'b1;
    wait_req(1'b0, 6, n, ok);
    e_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      e = CLK_EN_24_N;
      cycle();
      if (e) e_cnt++;
    end
    WDOG_DIS = 1'b1;
    wait_req(1'b1, 60, n, ok);
    checks++;
    if (!ok || e_cnt + n != PULSE) begin
      failures++;
      $display("FAIL disable_mid_pulse: enables=%0d want %0d", e_cnt + n, PULSE);
    end
    WDOG_DIS = 1'b0;
    VBLANK   = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_freeze();
    kick_now();
    frame();
    en_hold = 1'b1;
    cycle();
    for (int i = 0; i < 20; i++) begin
      VBLANK    = (i % 6) < 3;
      WDOG_KICK = (i == 10);
      cycle();
    end
    WDOG_KICK = 1'b0;
    VBLANK    = 1'b0;
    cycle();
    checks++;
    if (WDOG_CNT !== 4'd1 || nRESET_REQ !== 1'b1) begin
      failures++;
      $display("FAIL freeze_hold: cnt=%0d req=%b want cnt=1 req=1", WDOG_CNT, nRESET_REQ);
    end
    en_hold = 1'b0;
    repeat (4) cycle();
    checks++;
    if (WDOG_CNT !== 4'd0) begin
      failures++;
      $display("FAIL freeze_pending_kick: cnt=%0d want 0", WDOG_CNT);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n, e_cnt; bit ok;
    logic e;
    kick_now();
    frame();
    #2 nRESET = 1'b0;
    #1;
    checks++;
    if (nRESET_REQ !== 1'b0 || WDOG_CNT !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_run: req=%b cnt=%0d want req=0 cnt=0", nRESET_REQ, WDOG_CNT);
    end
    cycle();
    nRESET = 1'b1;
    wait_req(1'b1, 200, n, ok);
    frame();
    frame();
    VBLANK = 1'b1;
    wait_req(1'b0, 6, n, ok);
    e_cnt = 0;
    for (int i = 0; i < 20 && e_cnt < 4; i++) begin
      e = CLK_EN_24_N;
      cycle();
      if (e) e_cnt++;
    end
    #2 nRESET = 1'b0;
    #1;
    checks++;
    if (nRESET_REQ !== 1'b0 || WDOG_CNT !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_pulse: req=%b cnt=%0d want req=0 cnt=0", nRESET_REQ, WDOG_CNT);
    end
    VBLANK = 1'b0;
    repeat (3) cycle();
    nRESET = 1'b1;
    wait_req(1'b1, 200, n, ok);
    checks++;
    if (!ok || n != POR) begin
      failures++;
      $display("FAIL por_after_pulse: ok=%0d enables=%0d want %0d", ok, n, POR);
    end
  endtask

`ifdef NEO_WDOG_STATUS_EN
  task automatic test_status();
    int n; bit ok;
    kick_now();
    frame(); frame(); frame();
    wait_req(1'b1, 60, n, ok);
    checks++;
    if (WDOG_FIRED !== 1'b1) begin
      failures++;
      $display("FAIL status_set: fired=%b want 1", WDOG_FIRED);
    end
    WDOG_CLR = 1'b1;
    cycle();
    WDOG_CLR = 1'b0;
    checks++;
    if (WDOG_FIRED !== 1'b0) begin
      failures++;
      $display("FAIL status_clr: fired=%b want 0", WDOG_FIRED);
    end
    frame();
    frame();
    if (!CLK_EN_24_N) cycle();
    VBLANK   = 1'b1;
    WDOG_CLR = 1'b1;
    cycle();
    WDOG_CLR = 1'b0;
    checks++;
    if (WDOG_FIRED !== 1'b1 || nRESET_REQ !== 1'b0) begin
      failures++;
      $display("FAIL status_set_wins: fired=%b req=%b want fired=1 req=0", WDOG_FIRED, nRESET_REQ);
    end
    wait_req(1'b1, 60, n, ok);
    VBLANK = 1'b0;
    repeat (4) cycle();
  endtask
`endif

  // scoreboard-checked random traffic against the reference model
  task automatic test_random();
    int vb_timer = 5;
    int bad_cnt  = 0;
    for (int c = 0; c < 3000; c++) begin
      if (vb_timer == 0) begin
        VBLANK   = ~VBLANK;
        vb_timer = $urandom_range(3, 14);
      end else begin
        vb_timer--;
      end
      WDOG_KICK = ($urandom_range(0, 99) < 2);
      WDOG_CLR  = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 199) == 0) WDOG_DIS = ~WDOG_DIS;
      if (!en_hold && $urandom_range(0, 99) == 0) en_hold = 1'b1;
      else if (en_hold && $urandom_range(0, 9) == 0) en_hold = 1'b0;
      if ($urandom_range(0, 499) == 0) nRESET = 1'b0;
      else nRESET = 1'b1;
      cycle();
      checks++;
      if (nRESET_REQ !== m_req || WDOG_CNT !== 4'(m_frames)) begin
        failures++;
        if (bad_cnt < 10)
          $display("FAIL random_c%0d: req=%b cnt=%0d want req=%b cnt=%0d", c, nRESET_REQ, WDOG_CNT, m_req, m_frames);
        bad_cnt++;
      end
      checks++;
      if (WDOG_CNT > 4'(FRM - 1)) begin
        failures++;
        $display("FAIL random_cnt_bound_c%0d: cnt=%0d max %0d", c, WDOG_CNT, FRM - 1);
      end
`ifdef NEO_WDOG_STATUS_EN
      checks++;
      if (WDOG_FIRED !== m_fired) begin
        failures++;
        $display("FAIL random_fired_c%0d: fired=%b want %b", c, WDOG_FIRED, m_fired);
      end
`endif
    end
    nRESET    = 1'b1;
    WDOG_KICK = 1'b0;
    WDOG_CLR  = 1'b0;
    WDOG_DIS  = 1'b0;
    en_hold   = 1'b0;
  endtask

  initial begin
    nRESET      = 1'b0;
    CLK_EN_24_N = 1'b0;
    VBLANK      = 1'b0;
    WDOG_KICK   = 1'b0;
    WDOG_DIS    = 1'b0;
    WDOG_CLR    = 1'b0;
    test_reset();
    test_timeout();
    test_kick_nonenable();
    test_kick_coincident();
    test_disable();
    test_freeze();
    test_reset_mid_pulse();
`ifdef NEO_WDOG_STATUS_EN
    test_status();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neo_wdog_rstgen.md
Name: neo_wdog_rstgen

Overview:
- Generates the system reset request `nRESET_REQ` consumed by the downstream reset synchroniser.
  - That synchroniser produces `nRESETP` from `nRESET` on the 24M enable.
- Combines two reset sources:
  - Power-on hold after the async reset releases.
  - NeoGeo watchdog: the 68k must kick it at least once every `WDOG_FRAMES` VBLANK periods, or a stretched reset pulse is issued.
- Runs on the 24M clock-enable domain.

Parameters:
- `POR_CYCLES`, 4096: 24M enables `nRESET_REQ` is held low after async reset release; must be ≥ 1.
- `WDOG_FRAMES`, 8: VBLANK rising edges without a kick before the watchdog fires; range 1..15.
- `PULSE_CYCLES`, 256: 24M enables `nRESET_REQ` is held low after a watchdog fire; must be ≥ 1.

Ports:
- `CLK` in 1: master clock.
- `nRESET` in 1: async active-low reset, the only reset.
- `CLK_EN_24_N` in 1: 24M clock enable; all state advances only when high.
- `VBLANK` in 1: vertical blank level, synchronous to `CLK`.
- `WDOG_KICK` in 1: one-`CLK` pulse from the 68k write decode of 0x300001.
- `WDOG_DIS` in 1: level; 1 disables the watchdog (debug/menu).
- `nRESET_REQ` out 1: reset request to the synchroniser; low = reset.
- `WDOG_CNT` out 4: current frame count, for debug.

Behaviour:
- Clock and reset are fixed: one clock `CLK`; `nRESET` asynchronous active-low. While `nRESET` is low, all registers are cleared at once:
  - state = POR
  - `nRESET_REQ` = 0
  - `WDOG_CNT` = 0
  - pulse counter = 0
  - `kick_pend` = 0
  - `vb_d` = 0
- `WDOG_KICK` is captured every `CLK` into sticky `kick_pend`, so a kick on a non-enable cycle is not lost. `kick_pend` clears on the next enable cycle that consumes it.
- VBLANK edge: `vb_d` is registered on enable cycles; `vb_rise = VBLANK & ~vb_d`, evaluated on enable cycles only.
- `nRESET_REQ` is a registered output: low in POR and PULSE, high in RUN.
- States:
  - POR:
    - The pulse counter increments each enable.
    - When it reaches `POR_CYCLES-1`, go to RUN and clear the counter.
    - `nRESET_REQ` goes high on the same enable edge as the transition.
  - RUN:
    - If `kick_pend` or `WDOG_DIS`: `WDOG_CNT` ← 0. Kick priority beats a simultaneous `vb_rise`.
    - Else if `vb_rise`: `WDOG_CNT` ← `WDOG_CNT`+1.
    - If `vb_rise` occurs with `WDOG_CNT == WDOG_FRAMES-1` and no kick: go to PULSE, `WDOG_CNT` ← 0, `nRESET_REQ` ← 0 on that edge.
  - PULSE:
    - The pulse counter increments each enable; kicks and VBLANK are ignored (`kick_pend` cleared).
    - At `PULSE_CYCLES-1`, go to RUN and release `nRESET_REQ` on that edge.
- Boundaries:
  - `WDOG_CNT` never exceeds `WDOG_FRAMES-1` and never wraps.
  - Asserting `WDOG_DIS` during PULSE does not shorten the pulse.
  - `nRESET` low mid-PULSE returns to POR; the full `POR_CYCLES` then applies.
  - With `CLK_EN_24_N` stuck low, state is frozen; only `kick_pend` may set.
- Latency:
  - Fire edge to `nRESET_REQ` low: 0 enables (same edge).
  - Release: exactly `PULSE_CYCLES` enables low.

Optional Feature:
- Macro: `NEO_WDOG_STATUS_EN`.
- Defined: adds ports `WDOG_FIRED` out 1 and `WDOG_CLR` in 1.
  - `WDOG_FIRED` is a sticky flag, set on entry to PULSE.
  - Cleared by `WDOG_CLR` on any `CLK`; set wins if both happen on the same cycle.
  - Async reset clears it.
  - It is visible to the menu so it can report "watchdog reset occurred".
- Undefined: ports absent, no flag logic; all other behaviour identical.

Decomposition:
- Shared package `neo_rst_pkg`:
  - state enum `{POR, RUN, PULSE}` as 2-bit localparams.
  - `WDOG_CNT_W` = 4.
  - Default cycle constants.
- One natural sub-module: `neo_rst_stretch`, a loadable down/up pulse counter with a done flag. It is used by both POR and PULSE, with its length selected by the state.
- The top level holds the FSM, kick capture and VBLANK edge detect.

Test Plan (sim parameters `POR_CYCLES`=16, `WDOG_FRAMES`=3, `PULSE_CYCLES`=8, `CLK_EN_24_N` = every 2nd `CLK`):
- Power-on: release `nRESET` → `nRESET_REQ` low for exactly 16 enables, then high; `WDOG_CNT`=0.
- Timeout: no kicks, 3 `VBLANK` rising edges → `WDOG_CNT` 1, 2, then on the 3rd edge `nRESET_REQ`=0 for exactly 8 enables; `WDOG_CNT`=0 after.
- Kick on a non-enable `CLK` cycle between frames 2 and 3 → `WDOG_CNT` returns to 0; 2 further edges give no reset; the 3rd fires.
- Kick coincident with the `vb_rise` enable at `WDOG_CNT`=2 → no fire, `WDOG_CNT`=0.
- `WDOG_DIS`=1 across 20 frames → `WDOG_CNT` stays 0, `nRESET_REQ` stays 1. Assert `WDOG_DIS` mid-PULSE → the pulse still lasts 8 enables.
- `nRESET` pulsed low at PULSE enable 4 → outputs reset immediately; a full 16-enable POR follows. With `NEO_WDOG_STATUS_EN`: `WDOG_FIRED`=1 after a timeout, 0 after `WDOG_CLR`, and set wins when set and clear coincide.
